sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001: Parameter RD_CYC, default 2, SHALL set the read strobe length in clock cycles (legal 1..15).
REQ-002: Parameter WR_CYC, default 2, SHALL set the write-enable pulse length in clock cycles (legal 1..15).
REQ-003: Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004: Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005: Port req_rd, input, 1, SHALL be the pipeline read request.
REQ-006: Port req_wr, input, 1, SHALL be the pipeline write request.
REQ-007: Port addr, input, 18, SHALL be the request word address.
REQ-008: Port wdata, input, 16, SHALL be the write data.
REQ-009: Port rdata, output, 16, SHALL be the registered read result.
REQ-010: Port busy, output, 1, SHALL be the stall indication to the pipeline.
REQ-011: Port done, output, 1, SHALL be the one-cycle completion pulse.
REQ-012: Port ram_addr, output, 18, SHALL be the SRAM address.
REQ-013: Port ram_data, inout, 16, SHALL be the SRAM data bus.
REQ-014: Ports ram_en_n, ram_oe_n and ram_we_n, output, 1 each, SHALL be the active-low SRAM chip-enable, output-enable and write-enable.

Function
REQ-015: FSM states SHALL be IDLE, RD_ACT, WR_SETUP, WR_PULSE and WR_HOLD; all SRAM control outputs SHALL be registered (glitch-free).
REQ-016: In IDLE with done=0, a high req_wr or req_rd SHALL be accepted: addr and wdata latched, next state WR_SETUP or RD_ACT.
REQ-017: When req_wr and req_rd are high together, the write SHALL win and the read SHALL be dropped.
REQ-018: Requests SHALL be ignored when state≠IDLE or done=1; the requester holds the request until done, then deasserts it.
REQ-019: busy SHALL be 1 exactly when state≠IDLE.
REQ-020: RD_ACT SHALL last RD_CYC cycles with ram_en_n=0, ram_oe_n=0, ram_we_n=1 and ram_data hi-Z.
REQ-021: On the edge that leaves RD_ACT, rdata SHALL capture ram_data and the FSM SHALL return to IDLE with done=1.
REQ-022: WR_SETUP SHALL last 1 cycle: ram_en_n=0, ram_we_n=1, ram_oe_n=1, ram_data driven with latched wdata.
REQ-023: WR_PULSE SHALL last WR_CYC cycles with ram_we_n=0; other write signals as in WR_SETUP.
REQ-024: WR_HOLD SHALL last 1 cycle with ram_we_n=1 and data still driven; it SHALL then return to IDLE with done=1.
REQ-025: ram_data SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD, and SHALL be hi-Z otherwise.
REQ-026: ram_addr SHALL hold the latched address from acceptance until the next accepted request.
REQ-027: In IDLE, ram_en_n, ram_oe_n and ram_we_n SHALL all be 1.
REQ-028: done SHALL be high for exactly one cycle per completed operation.
REQ-029: rdata SHALL be unchanged by writes and SHALL hold until the next read completes.
REQ-030: Read latency SHALL be RD_CYC edges from the accepting edge to done=1; write latency SHALL be WR_CYC+2 edges.
REQ-031: The internal cycle counter SHALL be 4 bits; it SHALL reload on each state entry and SHALL not wrap within a state.

Reset
REQ-032: When rst is asserted, including mid-operation, the design SHALL immediately force state=IDLE, busy=0, done=0, rdata=0, ram_addr=0, ram_en_n=1, ram_oe_n=1, ram_we_n=1 and ram_data hi-Z.
REQ-033: An operation interrupted by reset SHALL be abandoned, with no done pulse and no resumption.
REQ-034: The first request SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-035: Read, RD_CYC=2, addr=0x00010, SRAM model returns 0xBEEF -> ram_oe_n low 2 cycles, done pulse 2 edges after acceptance, rdata=0xBEEF, busy high 2 cycles.
REQ-036: Write, WR_CYC=2, addr=0x3FFFF, wdata=0x1234 -> ram_we_n low exactly 2 cycles, bracketed by 1 setup and 1 hold cycle with data=0x1234; done 4 edges after acceptance; read-back returns 0x1234.
REQ-037: req_wr=req_rd=1 together, addr=0x00005, wdata=0xA5A5 -> only a write occurs, ram_oe_n never low, rdata unchanged.
REQ-038: Requester holds req_rd through the done cycle, then drops it -> exactly one read performed, no second acceptance.
REQ-039: rst pulsed during WR_PULSE -> ram_we_n=1 and ram_data hi-Z asynchronously, no done; a subsequent read completes normally.
REQ-040: Back-to-back operations: write 0x00001←0x0F0F, then read 0x00001 on the cycle after done -> rdata=0x0F0F, no bus contention (ram_data never driven while ram_oe_n=0).

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response bundle for the SRAM controller.
// The master drives requests; the slave (controller) returns status and data.
interface sram_ctrl_if;
    logic        req_rd;
    logic        req_wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        done;

    modport master (
        output req_rd, req_wr, addr, wdata,
        input  rdata, busy, done
    );

    modport slave (
        input  req_rd, req_wr, addr, wdata,
        output rdata, busy, done
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller with programmable read strobe and write pulse.
// All SRAM pins come straight from flops so they never glitch.
module sram_ctrl #(
    parameter int unsigned RD_CYC = 2,
    parameter int unsigned WR_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    output logic [17:0] ram_addr,
    inout  wire  [15:0] ram_data,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [3:0] RD_LD = 4'(RD_CYC - 1);
    localparam logic [3:0] WR_LD = 4'(WR_CYC - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        done_q;
    logic [15:0] rdata_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic        en_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        drv_q;

    // Controller FSM; every SRAM control output is set on the edge entering a state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            rdata_q <= 16'd0;
            addr_q  <= 18'd0;
            wdata_q <= 16'd0;
            en_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!done_q && (bus.req_wr || bus.req_rd)) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        en_n_q  <= 1'b0;
                        if (bus.req_wr) begin
                            state_q <= WR_SETUP;
                            drv_q   <= 1'b1;
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= RD_ACT;
                            oe_n_q  <= 1'b0;
                            cnt_q   <= RD_LD;
                        end
                    end
                end
                RD_ACT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q <= ram_data;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        en_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    we_n_q  <= 1'b0;
                    cnt_q   <= WR_LD;
                end
                WR_PULSE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WR_HOLD;
                        we_n_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_HOLD: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    en_n_q  <= 1'b1;
                    drv_q   <= 1'b0;
                    cnt_q   <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

    assign ram_addr = addr_q;
    assign ram_en_n = en_n_q;
    assign ram_oe_n = oe_n_q;
    assign ram_we_n = we_n_q;
    assign ram_data = drv_q ? wdata_q : 16'bz;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed vector table, corner sequences and
// random transactions checked against a transaction-level memory model.
module tb_sram_ctrl;
    localparam int RD_CYC = 2;
    localparam int WR_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if bus();
    wire  [15:0] ram_data;
    logic [17:0] ram_addr;
    logic        ram_en_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    sram_ctrl #(.RD_CYC(RD_CYC), .WR_CYC(WR_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_en_n (ram_en_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n)
    );

    // SRAM device model
    logic [15:0] sram [0:262143];
    logic        sram_drv;
    logic [15:0] sram_q;
    assign sram_drv = !ram_en_n && !ram_oe_n && ram_we_n;
    assign sram_q   = sram[ram_addr];
    assign ram_data = sram_drv ? sram_q : 16'bz;

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'd0;
        sram[18'h00010] = 16'hBEEF;
        forever begin
            @(negedge clk);
            if (!ram_en_n && !ram_we_n) sram[ram_addr] = ram_data;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    always @(negedge clk) if (bus.done) n_done++;

    // Transaction-level reference: memory contents plus last read result
    logic [15:0] ref_mem [int];
    logic [15:0] ref_rdata = 16'd0;

    function automatic logic [15:0] ref_op(bit wr, bit rd,
                                           logic [17:0] a, logic [15:0] d);
        if (wr) begin
            ref_mem[int'(a)] = d;
        end else if (rd) begin
            ref_rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'd0;
        end
        return ref_rdata;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic run_op(input bit wr, input bit rd, input logic [17:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd,
                          input bit hold, input string nm);
        int lat, busy_hi, oe_lo, we_lo, wside, bad_d, bad_a, cont;
        int exp_lat;
        bit got;
        exp_lat = wr ? WR_CYC + 2 : RD_CYC;
        lat = 0; busy_hi = 0; oe_lo = 0; we_lo = 0;
        wside = 0; bad_d = 0; bad_a = 0; cont = 0; got = 0;
        @(negedge clk);
        chk({nm, ":idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
        bus.req_wr = wr;
        bus.req_rd = rd;
        bus.addr   = a;
        bus.wdata  = d;
        @(posedge clk);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            busy_hi += int'(bus.busy);
            oe_lo   += int'(!ram_oe_n);
            we_lo   += int'(!ram_we_n);
            if (!ram_en_n && ram_oe_n && ram_we_n) wside++;
            if (!ram_en_n && ram_oe_n && ram_data !== d) bad_d++;
            if (ram_addr !== a) bad_a++;
            if (!ram_oe_n && (!ram_we_n || ram_data !== sram_q)) cont++;
            if (bus.done) begin
                got = 1;
                lat = k;
            end
        end
        chk({nm, ":done_seen"}, {31'd0, got}, 32'd1);
        chk({nm, ":latency"}, lat, exp_lat);
        chk({nm, ":busy_cyc"}, busy_hi, exp_lat);
        chk({nm, ":oe_cyc"}, oe_lo, (rd && !wr) ? RD_CYC : 0);
        chk({nm, ":we_cyc"}, we_lo, wr ? WR_CYC : 0);
        chk({nm, ":setup_hold"}, wside, wr ? 2 : 0);
        chk({nm, ":wr_data"}, bad_d, 0);
        chk({nm, ":addr"}, bad_a, 0);
        chk({nm, ":contention"}, cont, 0);
        chk({nm, ":rdata"}, {16'd0, bus.rdata}, {16'd0, exp_rd});
        if (hold) @(negedge clk);
        bus.req_wr = 1'b0;
        bus.req_rd = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [17:0] a;
        logic [15:0] d;
        logic [15:0] exp_rd;
        string       nm;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int snap;
        logic [15:0] e;
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        bus.addr   = 18'd0;
        bus.wdata  = 16'd0;
        ref_mem[16] = 16'hBEEF;

        tbl[0] = '{0, 1, 18'h00010, 16'h0000, 16'hBEEF, "rd_beef"};
        tbl[1] = '{1, 0, 18'h3FFFF, 16'h1234, 16'hBEEF, "wr_top"};
        tbl[2] = '{0, 1, 18'h3FFFF, 16'h0000, 16'h1234, "rd_top"};
        tbl[3] = '{1, 1, 18'h00005, 16'hA5A5, 16'h1234, "wr_rd_both"};
        tbl[4] = '{0, 1, 18'h00005, 16'h0000, 16'hA5A5, "rd_both"};
        tbl[5] = '{1, 0, 18'h00001, 16'h0F0F, 16'hA5A5, "b2b_wr"};
        tbl[6] = '{0, 1, 18'h00001, 16'h0000, 16'h0F0F, "b2b_rd"};

        #12;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
        chk("rst_addr", {14'd0, ram_addr}, 32'd0);
        chk("rst_ctl", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'd7);

        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            e = ref_op(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
            run_op(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d,
                   tbl[i].exp_rd, 1'b0, tbl[i].nm);
        end

        @(negedge clk);
        #1 snap = n_done;
        e = ref_op(1'b0, 1'b1, 18'h00010, 16'h0);
        run_op(1'b0, 1'b1, 18'h00010, 16'h0, e, 1'b1, "hold_rd");
        repeat (3) @(negedge clk);
        chk("hold_busy", {31'd0, bus.busy}, 32'd0);
        chk("hold_one_done", n_done - snap, 1);

        @(negedge clk);
        bus.req_wr = 1'b1;
        bus.addr   = 18'h2AAAA;
        bus.wdata  = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_low", {31'd0, ram_we_n}, 32'd0);
        snap = n_done;
        #2 rst = 1'b1;
        #1;
        chk("abort_ctl", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'd7);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_rdata", {16'd0, bus.rdata}, 32'd0);
        chk("abort_addr", {14'd0, ram_addr}, 32'd0);
        bus.req_wr = 1'b0;
        ref_rdata  = 16'd0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", n_done - snap, 0);
        chk("abort_idle", {31'd0, bus.busy}, 32'd0);
        e = ref_op(1'b0, 1'b1, 18'h3FFFF, 16'h0);
        run_op(1'b0, 1'b1, 18'h3FFFF, 16'h0, e, 1'b0, "post_rst_rd");

        for (int i = 0; i < 30; i++) begin
            int unsigned sel;
            logic [17:0] a;
            logic [15:0] d;
            sel = $urandom_range(0, 2);
            a   = 18'h00100 + 18'($urandom_range(0, 15));
            d   = 16'($urandom);
            e   = ref_op(sel != 0, sel != 1, a, d);
            run_op(sel != 0, sel != 1, a, d, e, 1'b0, "rand");
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
